// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, line levels and frame helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + 8 + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous FIFO with registered full/empty/count
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // Full is judged on the registered count, so a pop on the same edge does not open a slot.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
            count_q  <= count_d;
            full_q   <= (count_d == (AW+1)'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART serializer with optional parity and 1 or 2 stop bits
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        data_q;
    logic              serial_q, active_q, done_q, ovf_q;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [7:0]        fifo_rdata;
    logic              baud_last, stop_last;

    uart_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_ni  (i_Rst_n),
        .push_i  (i_Tx_DV),
        .pop_i   (fifo_pop),
        .wdata_i (i_Tx_Byte),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_Fifo_Count)
    );

    always_comb begin
        baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        stop_last = baud_last && (bit_idx_q == 3'(STOP_BITS - 1));
        // Popping in the last stop cycle chains frames with no idle gap.
        fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_last));
    end

    // The line register follows the state one clock later, so every output is a flop.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            serial_q  <= LINE_IDLE;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q    <= i_Tx_DV && fifo_full;
            active_q <= (state_q != ST_IDLE);
            done_q   <= (state_q == ST_STOP) && stop_last;

            case (state_q)
                ST_START:  serial_q <= LINE_START;
                ST_DATA:   serial_q <= data_q[bit_idx_q];
                ST_PARITY: serial_q <= (^data_q) ^ (PARITY_ODD != 0);
                ST_STOP:   serial_q <= LINE_STOP;
                default:   serial_q <= LINE_IDLE;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        data_q    <= fifo_rdata;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (stop_last) begin
                            bit_idx_q <= '0;
                            if (fifo_pop) begin
                                data_q  <= fifo_rdata;
                                state_q <= ST_START;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Tx_Ready  = !fifo_full;
    assign o_Overflow  = ovf_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for three transmitter configurations sharing one byte stream
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int ND    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dv = 1'b0;
    logic [7:0]    byt = 8'h00;
    logic [ND-1:0] rdy, ovf, act, ser, don;
    logic [2:0]    cnt [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        uart_tx_buffered #(
            .CLKS_PER_BIT (CPB),
            .FIFO_DEPTH   (DEPTH),
            .PARITY_EN    ((g == 0) ? 0 : 1),
            .PARITY_ODD   ((g == 2) ? 1 : 0),
            .STOP_BITS    ((g == 1) ? 2 : 1)
        ) u_dut (
            .i_Clock      (clk),
            .i_Rst_n      (rst_n),
            .i_Tx_DV      (dv),
            .i_Tx_Byte    (byt),
            .o_Tx_Ready   (rdy[g]),
            .o_Fifo_Count (cnt[g]),
            .o_Overflow   (ovf[g]),
            .o_Tx_Active  (act[g]),
            .o_Tx_Serial  (ser[g]),
            .o_Tx_Done    (don[g])
        );
    end

    function automatic int pe_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int po_of(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic int sb_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return CPB * (9 + pe_of(i) + sb_of(i));
    endfunction

    int         checks = 0;
    int         errors = 0;
    int         ecnt = 0;
    logic       chk_en = 1'b0;
    logic       final_req = 1'b0;
    logic       final_done = 1'b0;

    logic [7:0] mq  [ND][$];
    logic [7:0] sbq [ND][$];
    int         fp [ND];
    int         nf [ND];
    logic [7:0] fb [ND];
    logic [ND-1:0] e_ser, e_act, e_don, e_rdy, e_ovf;
    int         e_cnt [ND];
    logic [ND-1:0] inf;
    int         pos [ND];
    logic [11:0] bits [ND];

    task automatic chk(input string nm, input int i, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[%0d] edge %0d got %0h want %0h", nm, i, ecnt, got, want);
        end
    endtask

    always @(negedge clk) begin : model_and_monitor
        int L, o, b, sz;
        logic acc;
        logic [7:0] want;
        logic [11:0] ef;

        if (!rst_n) begin
            for (int i = 0; i < ND; i++) begin
                mq[i].delete();
                sbq[i].delete();
                fp[i] = -100000;
                nf[i] = 0;
                inf[i] = 1'b0;
                e_ser[i] = 1'b1; e_act[i] = 1'b0; e_don[i] = 1'b0;
                e_rdy[i] = 1'b1; e_ovf[i] = 1'b0; e_cnt[i] = 0;
            end
        end

        if (chk_en) begin
            for (int i = 0; i < ND; i++) begin
                chk("serial",   i, int'(ser[i]), int'(e_ser[i]));
                chk("active",   i, int'(act[i]), int'(e_act[i]));
                chk("done",     i, int'(don[i]), int'(e_don[i]));
                chk("ready",    i, int'(rdy[i]), int'(e_rdy[i]));
                chk("overflow", i, int'(ovf[i]), int'(e_ovf[i]));
                chk("count",    i, int'(cnt[i]), e_cnt[i]);
            end
        end

        if (rst_n) begin
            // Receiver: find the start edge, sample mid-bit, compare whole frames.
            for (int i = 0; i < ND; i++) begin
                L = frame_len(i);
                if (inf[i]) begin
                    pos[i]++;
                end else if (ser[i] == 1'b0) begin
                    inf[i] = 1'b1;
                    pos[i] = 0;
                    bits[i] = 12'hFFF;
                end
                if (inf[i]) begin
                    if (pos[i] % CPB == CPB / 2) bits[i][pos[i] / CPB] = ser[i];
                    if (pos[i] == L - 1) begin
                        inf[i] = 1'b0;
                        if (sbq[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame[%0d] edge %0d got unexpected frame %0h want none", i, ecnt, bits[i]);
                        end else begin
                            want = sbq[i].pop_front();
                            ef = 12'hFFF;
                            ef[0] = 1'b0;
                            ef[8:1] = want;
                            if (pe_of(i) != 0) ef[9] = (^want) ^ (po_of(i) != 0);
                            chk("frame", i, int'(bits[i]), int'(ef));
                        end
                    end
                end
            end

            // Reference: queue plus the edge at which each frame was launched.
            ecnt++;
            for (int i = 0; i < ND; i++) begin
                L = frame_len(i);
                if (ecnt > fp[i] && ecnt <= fp[i] + L) begin
                    o = ecnt - fp[i] - 1;
                    b = o / CPB;
                    if (b == 0)                          e_ser[i] = 1'b0;
                    else if (b <= 8)                     e_ser[i] = fb[i][b-1];
                    else if (pe_of(i) != 0 && b == 9)    e_ser[i] = (^fb[i]) ^ (po_of(i) != 0);
                    else                                 e_ser[i] = 1'b1;
                    e_act[i] = 1'b1;
                    e_don[i] = (ecnt == fp[i] + L);
                end else begin
                    e_ser[i] = 1'b1;
                    e_act[i] = 1'b0;
                    e_don[i] = 1'b0;
                end
                sz = mq[i].size();
                acc = dv && (sz < DEPTH);
                e_ovf[i] = dv && !acc;
                if (sz > 0 && ecnt >= nf[i]) begin
                    fb[i] = mq[i].pop_front();
                    fp[i] = ecnt;
                    nf[i] = ecnt + L;
                end
                if (acc) begin
                    mq[i].push_back(byt);
                    sbq[i].push_back(byt);
                end
                e_cnt[i] = mq[i].size();
                e_rdy[i] = (mq[i].size() < DEPTH);
            end
        end

        if (final_req && !final_done) begin
            for (int i = 0; i < ND; i++) begin
                chk("undelivered", i, sbq[i].size(), 0);
                chk("rx_busy", i, int'(inf[i]), 0);
            end
            final_done = 1'b1;
        end
    end

    task automatic write(input logic [7:0] b);
        @(posedge clk);
        #1;
        dv = 1'b1;
        byt = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dv = 1'b0;
        end
    endtask

    initial begin
        int rate;
        rate = 3;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);

        write(8'h7D);
        idle(60);

        write(8'h55); write(8'hA3); write(8'h00);
        idle(160);

        for (int k = 1; k <= 7; k++) write(8'(k));
        idle(300);

        write(8'h00); write(8'hFF); write(8'h7D); write(8'h80);
        idle(250);

        write(8'h7D); write(8'h11); write(8'h22);
        idle(18);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(30);

        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) rate = $urandom_range(1, 9);
            @(posedge clk);
            #1;
            dv = ($urandom_range(0, 9) < rate);
            byt = 8'($urandom);
        end
        idle(320);

        final_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
